// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port DRAM arbiter with fixed-latency strobes; ARB_ROUND_ROBIN_EN selects round-robin ties
module dram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          We0,
    input  logic          We1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Wdata0,
    input  logic [DW-1:0] Wdata1,
    output logic          Ack0,
    output logic          Ack1,
    output logic [DW-1:0] Rdata0,
    output logic [DW-1:0] Rdata1,
    output logic [AW-1:0] MemAddr,
    output logic          MemRD,
    output logic          MemWR,
    output logic [DW-1:0] MemDataOut,
    input  logic [DW-1:0] MemDataIn,
    output logic          Busy,
    output logic          Owner
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          we_q, we_nxt;
    logic          last_owner, last_owner_nxt;
    logic          owner_nxt;
    logic [AW-1:0] addr_nxt;
    logic          rd_nxt, wr_nxt;
    logic [DW-1:0] dout_nxt;
    logic          ack0_nxt, ack1_nxt;
    logic [DW-1:0] rdata0_nxt, rdata1_nxt;
    logic          busy_nxt;

    logic          win;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    // Pick the winning port and mux its request fields.
    always_comb begin
        win = 1'b0;
        if (Req0 && Req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = ~last_owner;
`else
            win = 1'b0;
`endif
        end else if (Req1) begin
            win = 1'b1;
        end
        g_we    = win ? We1    : We0;
        g_addr  = win ? Addr1  : Addr0;
        g_wdata = win ? Wdata1 : Wdata0;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        we_nxt         = we_q;
        last_owner_nxt = last_owner;
        owner_nxt      = Owner;
        addr_nxt       = MemAddr;
        rd_nxt         = MemRD;
        wr_nxt         = MemWR;
        dout_nxt       = MemDataOut;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        rdata0_nxt     = '0;
        rdata1_nxt     = '0;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_nxt      = ACCESS;
                    cnt_nxt        = CNT_LOAD;
                    owner_nxt      = win;
                    last_owner_nxt = win;
                    we_nxt         = g_we;
                    addr_nxt       = g_addr;
                    rd_nxt         = ~g_we;
                    wr_nxt         = g_we;
                    dout_nxt       = g_we ? g_wdata : '0;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Last strobe cycle: read data is valid on MemDataIn now.
                    state_nxt = DONE;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    dout_nxt  = '0;
                    ack0_nxt  = ~Owner;
                    ack1_nxt  = Owner;
                    if (!we_q) begin
                        if (Owner) begin
                            rdata1_nxt = MemDataIn;
                        end else begin
                            rdata0_nxt = MemDataIn;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset drops the strobes asynchronously.
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            last_owner <= 1'b1;
            Owner      <= 1'b0;
            MemAddr    <= '0;
            MemRD      <= 1'b0;
            MemWR      <= 1'b0;
            MemDataOut <= '0;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Rdata0     <= '0;
            Rdata1     <= '0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            we_q       <= we_nxt;
            last_owner <= last_owner_nxt;
            Owner      <= owner_nxt;
            MemAddr    <= addr_nxt;
            MemRD      <= rd_nxt;
            MemWR      <= wr_nxt;
            MemDataOut <= dout_nxt;
            Ack0       <= ack0_nxt;
            Ack1       <= ack1_nxt;
            Rdata0     <= rdata0_nxt;
            Rdata1     <= rdata1_nxt;
            Busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter
module tb_dram_arbiter;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
    logic [15:0] Addr0 = '0, Addr1 = '0, Wdata0 = '0, Wdata1 = '0;
    logic        Ack0, Ack1, MemRD, MemWR, Busy, Owner;
    logic [15:0] Rdata0, Rdata1, MemAddr, MemDataOut, MemDataIn;

    logic        Req0_b = 1'b0;
    logic [15:0] Addr0_b = '0;
    logic        Ack0_b, Ack1_b, MemRD_b, MemWR_b, Busy_b, Owner_b;
    logic [15:0] Rdata0_b, Rdata1_b, MemAddr_b, MemDataOut_b, MemDataIn_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run = 0;
    bit init_done = 1'b0;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [15:0] mem [0:255];

    dram_arbiter #(.AW(16), .DW(16), .MEM_LAT(2)) u_dut (
        .Clk1(Clk1), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Ack0(Ack0), .Ack1(Ack1), .Rdata0(Rdata0), .Rdata1(Rdata1),
        .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR),
        .MemDataOut(MemDataOut), .MemDataIn(MemDataIn),
        .Busy(Busy), .Owner(Owner)
    );

    dram_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_lat1 (
        .Clk1(Clk1), .Reset(Reset),
        .Req0(Req0_b), .Req1(1'b0), .We0(1'b0), .We1(1'b0),
        .Addr0(Addr0_b), .Addr1(16'h0000), .Wdata0(16'h0000), .Wdata1(16'h0000),
        .Ack0(Ack0_b), .Ack1(Ack1_b), .Rdata0(Rdata0_b), .Rdata1(Rdata1_b),
        .MemAddr(MemAddr_b), .MemRD(MemRD_b), .MemWR(MemWR_b),
        .MemDataOut(MemDataOut_b), .MemDataIn(MemDataIn_b),
        .Busy(Busy_b), .Owner(Owner_b)
    );

    always #5 Clk1 = ~Clk1;

    function automatic logic [15:0] init_val(input int i);
        if (i == 16'h10) return 16'hBEEF;
        if (i == 16'h11) return 16'hCAFE;
        if (i >= 16'h40 && i <= 16'h43) return 16'(16'h4000 + i - 16'h40);
        if (i == 16'h50 || i == 16'h51) return 16'(16'h5000 + i - 16'h50);
        if (i == 16'hFF) return 16'hDEAD;
        return 16'h0000;
    endfunction

    assign MemDataIn   = MemRD   ? mem[MemAddr[7:0]]   : 16'h0000;
    assign MemDataIn_b = MemRD_b ? mem[MemAddr_b[7:0]] : 16'h0000;

    // DRAM model: preload on the first edge, then accept writes.
    always @(posedge Clk1) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (MemWR) begin
            mem[MemAddr[7:0]] <= MemDataOut;
        end
    end

    always @(posedge Clk1) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each Ack and checks strobe shape.
    always @(negedge Clk1) begin
        if (Reset) begin
            run = 0;
        end else begin
            if (Ack0 && Ack1) chk("ack_both", 1, 0);
            if (Ack0 || Ack1) begin
                chk("strobe_in_done", {MemRD, MemWR}, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {Ack1, Ack0}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", Ack1, e.port);
                    chk("owner", Owner, e.port);
                    chk("rdata", Ack1 ? Rdata1 : Rdata0, e.data);
                    chk("rdata_nonowner", Ack1 ? Rdata0 : Rdata1, 0);
                end
            end
            if (MemRD || MemWR) begin
                run++;
            end else if (run != 0) begin
                chk("strobe_len", run, 2);
                run = 0;
            end
        end
    end

    task automatic run_port(input logic p, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        int n;
        if (!p) begin
            Req0 = 1'b1; We0 = we; Addr0 = addr; Wdata0 = wd;
        end else begin
            Req1 = 1'b1; We1 = we; Addr1 = addr; Wdata1 = wd;
        end
        n = 0;
        do begin
            @(negedge Clk1);
            n++;
        end while (!(p ? Ack1 : Ack0) && n < 300);
        if (!(p ? Ack1 : Ack0)) chk("ack_timeout", 0, 1);
        @(posedge Clk1); #1;
        if (!p) Req0 = 1'b0; else Req1 = 1'b0;
    endtask

    task automatic do_access(input logic p, input logic we, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [15:0] exp_rd);
        sb.push_back('{port: p, data: exp_rd});
        fork
            run_port(p, we, addr, wd);
            begin
                @(posedge Clk1);
                @(negedge Clk1);
                chk("mem_addr", MemAddr, addr);
                chk("mem_rd", MemRD, !we);
                chk("mem_wr", MemWR, we);
                chk("mem_dout", MemDataOut, we ? wd : 16'h0000);
            end
        join
    endtask

    task automatic wait_ack_b(output int t);
        int n;
        n = 0;
        do begin
            @(negedge Clk1);
            n++;
        end while (!Ack0_b && n < 50);
        if (!Ack0_b) chk("lat1_ack_timeout", 0, 1);
        t = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, t2;
        repeat (3) @(posedge Clk1);
        @(negedge Clk1);
        chk("rst_acks", {Ack0, Ack1}, 0);
        chk("rst_strobes", {MemRD, MemWR}, 0);
        chk("rst_busy_owner", {Busy, Owner}, 0);
        chk("rst_addr_dout", {MemAddr, MemDataOut}, 0);
        chk("rst_rdata", {Rdata0, Rdata1}, 0);
        @(posedge Clk1); #1;
        Reset = 1'b0;
        @(posedge Clk1); #1;
        chk("idle_busy", Busy, 0);

        do_access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        do_access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000);

        // Tie test: last owner is port 1 here, so port 0 wins the first tie.
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{port: 1'b0, data: 16'h4000});
        sb.push_back('{port: 1'b1, data: 16'h5000});
        sb.push_back('{port: 1'b0, data: 16'h4001});
        sb.push_back('{port: 1'b1, data: 16'h5001});
        fork
            begin for (int k = 0; k < 2; k++) run_port(1'b0, 1'b0, 16'(16'h40 + k), 16'h0); end
            begin for (int k = 0; k < 2; k++) run_port(1'b1, 1'b0, 16'(16'h50 + k), 16'h0); end
        join
`else
        for (int k = 0; k < 4; k++) sb.push_back('{port: 1'b0, data: 16'(16'h4000 + k)});
        sb.push_back('{port: 1'b1, data: 16'h5000});
        fork
            begin for (int k = 0; k < 4; k++) run_port(1'b0, 1'b0, 16'(16'h40 + k), 16'h0); end
            begin run_port(1'b1, 1'b0, 16'h0050, 16'h0); end
        join
`endif

        do_access(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234);

        sb.push_back('{port: 1'b0, data: 16'hBEEF});
        fork
            run_port(1'b0, 1'b0, 16'h0010, 16'h0000);
            begin
                @(posedge Clk1); #1;
                Addr0 = 16'h00FF;
                @(negedge Clk1);
                chk("addr_hold_1", MemAddr, 16'h0010);
                @(negedge Clk1);
                chk("addr_hold_2", MemAddr, 16'h0010);
            end
        join

        Req0 = 1'b1; We0 = 1'b1; Addr0 = 16'h0030; Wdata0 = 16'h5555;
        @(posedge Clk1); #1;
        chk("rst_mid_pre_wr", MemWR, 1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_wr", MemWR, 0);
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_ack", Ack0, 0);
        Req0 = 1'b0;
        @(posedge Clk1);
        @(posedge Clk1); #1;
        Reset = 1'b0;
        chk("rst_mid_mem", mem[8'h30], 16'h0000);
        @(posedge Clk1); #1;
        chk("rst_mid_idle", Busy, 0);
        do_access(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0000);
        do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555);

        Req0_b = 1'b1; Addr0_b = 16'h0010;
        wait_ack_b(t1);
        chk("lat1_rdata_a", Rdata0_b, 16'hBEEF);
        chk("lat1_rd_in_done_a", MemRD_b, 0);
        @(posedge Clk1); #1;
        Addr0_b = 16'h0011;
        wait_ack_b(t2);
        chk("lat1_rdata_b", Rdata0_b, 16'hCAFE);
        chk("lat1_rd_in_done_b", MemRD_b, 0);
        chk("lat1_ack_spacing", t2 - t1, 3);
        @(posedge Clk1); #1;
        Req0_b = 1'b0;

        repeat (6) @(posedge Clk1);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
